pulse_rate_detector: RTL
========================

Name: pulse_rate_detector

Overview:
- Receive-side companion of the mode-selectable pulse divider: takes the divided square wave (possibly from another board or clock domain) and recovers which rate the divider was set to.
- Synchronises the input into the I_CLK domain and measures each half-period in I_CLK cycles.
- Classifies each half-period as slow (M=1) or fast (M=0) and reports the decoded mode, a lock flag and error pulses.
- Sits between the divider output and any downstream counter or display that must know the active rate.

Parameters:
- CNT_W, 32, width of the interval counter and O_PERIOD.
- SLOW_CYC, 25000001, nominal I_CLK cycles between input edges in slow mode (M=1).
- FAST_CYC, 12500001, nominal I_CLK cycles between input edges in fast mode (M=0).
- TOL, 1024, allowed absolute deviation in cycles. Legal only if TOL < (SLOW_CYC-FAST_CYC)/2.
- TIMEOUT_CYC, 50000004, cycles without an edge before the block declares signal loss. Must exceed SLOW_CYC+TOL.

Ports:
- I_CLK  input  1  system clock.
- I_RST_N  input  1  asynchronous, active-low reset.
- I_PULSE  input  1  divided square wave, asynchronous to I_CLK.
- O_EDGE  output  1  one-cycle pulse per detected I_PULSE transition (either polarity).
- O_PERIOD  output  CNT_W  last measured edge-to-edge interval in cycles; holds until the next edge.
- O_MODE  output  1  decoded mode: 1 = slow, 0 = fast. Valid only while O_LOCK=1.
- O_LOCK  output  1  high while the rate is stable and classified.
- O_ERR  output  1  one-cycle pulse on an out-of-tolerance interval or a timeout.

Behaviour:
- Reset (async assert, sync release): sync flops=0, counter=0, O_PERIOD=0, O_MODE=0, O_LOCK=0, O_EDGE=0, O_ERR=0, state=IDLE, candidate class=NONE.
- Synchroniser: 2 flops (s1, s2) plus a history flop s3. Edge = s2 XOR s3, registered into O_EDGE. A transition on I_PULSE reaches O_EDGE on the 3rd–4th rising I_CLK edge.
- Counter: increments on every cycle with no edge and saturates at TIMEOUT_CYC. On an edge cycle: interval P = counter+1, counter <= 0.
- Classification of P: SLOW if |P-SLOW_CYC| <= TOL; FAST if |P-FAST_CYC| <= TOL; otherwise BAD. Compute the difference in CNT_W+1 bits with no wrap.
- States:
  - IDLE: waits for the first edge. That edge only starts timing: O_PERIOD is not updated and no classification is made. Goes to MEASURE.
  - MEASURE: on each edge, O_PERIOD <= P and P is classified.
    - BAD: O_ERR pulse, candidate <= NONE.
    - Class equals candidate: go to LOCKED, O_MODE <= class, O_LOCK <= 1 on the same cycle O_PERIOD updates.
    - Otherwise: candidate <= class.
  - LOCKED: on each edge, O_PERIOD <= P.
    - Same class: stay.
    - Other valid class: O_LOCK <= 0, no O_ERR, candidate <= new class, go to MEASURE. Relock needs one more matching interval.
    - BAD: O_LOCK <= 0, O_ERR pulse, candidate <= NONE, go to MEASURE.
- Timeout: counter reaches TIMEOUT_CYC in MEASURE or LOCKED → O_ERR pulse, O_LOCK <= 0, candidate <= NONE, state <= IDLE. No timeout is reported in IDLE.
- O_MODE holds its last locked value after unlock; consumers must qualify it with O_LOCK.
- Edge coinciding with the timeout cycle: the edge wins and no timeout is reported.
- Reset asserted mid-interval: all state is cleared immediately and the partial interval is discarded.

Decomposition:
- Shared package: class encoding (NONE/SLOW/FAST/BAD), state encoding (IDLE/MEASURE/LOCKED), and default SLOW_CYC/FAST_CYC so the divider and detector share one source of truth.
- One sub-module, pulse_sync_edge: 2-flop synchroniser plus edge detect, reusable for other async inputs.

Test Plan (overrides: SLOW_CYC=101, FAST_CYC=51, TOL=4, TIMEOUT_CYC=250):
- Reset, then toggle I_PULSE every 101 cycles → O_EDGE every 101 cycles; O_LOCK=1, O_MODE=1 at the 3rd edge; O_PERIOD=101; O_ERR never asserts.
- Locked slow, then switch to toggling every 51 cycles → O_LOCK drops at the first 51-cycle edge with no O_ERR; relocks at the next edge with O_MODE=0, O_PERIOD=51.
- Toggle every 75 cycles → each edge gives O_ERR=1 for one cycle; O_LOCK stays 0; O_PERIOD=75.
- Locked fast, then stop toggling → O_ERR pulse and O_LOCK=0 exactly 250 cycles after the last edge; no further O_ERR while idle.
- Tolerance edges: intervals of 97 and 105 classify SLOW (lock); 96 and 106 give O_ERR.
- Assert I_RST_N=0 mid-interval while locked → all outputs go to 0 asynchronously; after release, the first edge does not update O_PERIOD.

Source files
------------

// File: rtl/pulse_rate_detector_pkg.sv
// Shared encodings and default rates for the pulse divider / rate detector pair.
// Both sides take their nominal half-period lengths from here.
package pulse_rate_detector_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_SLOW = 2'd1,
        CLS_FAST = 2'd2,
        CLS_BAD  = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int unsigned DEF_SLOW_CYC    = 25000001;
    localparam int unsigned DEF_FAST_CYC    = 12500001;
    localparam int unsigned DEF_TOL         = 1024;
    localparam int unsigned DEF_TIMEOUT_CYC = 50000004;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser with a history flop for any-polarity edge detection.
// O_EDGE_NOW is the raw edge cycle; O_EDGE is the same pulse one clock later.
module pulse_sync_edge (
    input  logic I_CLK,
    input  logic I_RST_N,
    input  logic I_ASYNC,
    output logic O_EDGE_NOW,
    output logic O_EDGE
);

    logic s1, s2, s3;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            O_EDGE <= 1'b0;
        end else begin
            s1     <= I_ASYNC;
            s2     <= s1;
            s3     <= s2;
            O_EDGE <= s2 ^ s3;
        end
    end

    assign O_EDGE_NOW = s2 ^ s3;

endmodule

// File: rtl/pulse_rate_detector.sv
// Recovers the divider's rate setting from its square-wave output by timing
// each half-period and requiring two matching intervals before locking.
module pulse_rate_detector
    import pulse_rate_detector_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SLOW_CYC    = DEF_SLOW_CYC,
    parameter int unsigned FAST_CYC    = DEF_FAST_CYC,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic             I_PULSE,
    output logic             O_EDGE,
    output logic [CNT_W-1:0] O_PERIOD,
    output logic             O_MODE,
    output logic             O_LOCK,
    output logic             O_ERR
);

    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W:0]   SLOW_X = (CNT_W+1)'(SLOW_CYC);
    localparam logic [CNT_W:0]   FAST_X = (CNT_W+1)'(FAST_CYC);
    localparam logic [CNT_W:0]   TOL_X  = (CNT_W+1)'(TOL);

    // One extra bit keeps the absolute difference free of wraparound.
    function automatic cls_e classify(input logic [CNT_W-1:0] p);
        logic [CNT_W:0] px, ds, df;
        px = {1'b0, p};
        ds = (px >= SLOW_X) ? (px - SLOW_X) : (SLOW_X - px);
        df = (px >= FAST_X) ? (px - FAST_X) : (FAST_X - px);
        if (ds <= TOL_X)      return CLS_SLOW;
        else if (df <= TOL_X) return CLS_FAST;
        else                  return CLS_BAD;
    endfunction

    logic             edge_now;
    state_e           state_q, state_d;
    cls_e             cand_q, cand_d, cls;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, p;
    logic             mode_q, mode_d, lock_q, lock_d, err_q, err_d;
    logic             timeout;

    pulse_sync_edge u_sync (
        .I_CLK      (I_CLK),
        .I_RST_N    (I_RST_N),
        .I_ASYNC    (I_PULSE),
        .O_EDGE_NOW (edge_now),
        .O_EDGE     (O_EDGE)
    );

    assign p   = cnt_q + CNT_W'(1);
    assign cls = classify(p);
    // Fires on the cycle the counter reaches the limit; an edge on that cycle wins.
    assign timeout = !edge_now && (state_q != ST_IDLE) && (cnt_q == TO_M1);

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q  <= ST_IDLE;
            cand_q   <= CLS_NONE;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        lock_d   = lock_q;
        err_d    = 1'b0;

        if (edge_now)           cnt_d = '0;
        else if (cnt_q != TO_V) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (edge_now) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (edge_now) begin
                    period_d = p;
                    if (cls == CLS_BAD) begin
                        err_d  = 1'b1;
                        cand_d = CLS_NONE;
                    end else if (cls == cand_q) begin
                        state_d = ST_LOCKED;
                        mode_d  = (cls == CLS_SLOW);
                        lock_d  = 1'b1;
                    end else begin
                        cand_d = cls;
                    end
                end
            end
            ST_LOCKED: begin
                // cand_q still holds the locked class here
                if (edge_now) begin
                    period_d = p;
                    if (cls == CLS_BAD) begin
                        lock_d  = 1'b0;
                        err_d   = 1'b1;
                        cand_d  = CLS_NONE;
                        state_d = ST_MEASURE;
                    end else if (cls != cand_q) begin
                        lock_d  = 1'b0;
                        cand_d  = cls;
                        state_d = ST_MEASURE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            lock_d  = 1'b0;
            cand_d  = CLS_NONE;
            state_d = ST_IDLE;
        end
    end

    assign O_PERIOD = period_q;
    assign O_MODE   = mode_q;
    assign O_LOCK   = lock_q;
    assign O_ERR    = err_q;

endmodule
